// File: rtl/pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipe_skid_reg : elastic valid/ready pipeline register with one-entry skid   |
// | buffer; full throughput, in_ready driven straight from a flop.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pipe_skid_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  // Encoding doubles as the entry count so occupancy comes straight off the flops.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] main_nx;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] skid_nx;
  logic             in_xfer;
  logic             out_xfer;

  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = main_data;
  assign occupancy = state;

  always_comb begin
    state_nx = state;
    main_nx  = main_data;
    skid_nx  = skid_data;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nx = BUSY;
          main_nx  = in_data;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_nx = in_data;
        end else if (out_xfer) begin
          state_nx = EMPTY;
        end else if (in_xfer) begin
          state_nx = FULL;
          skid_nx  = in_data;
        end
      end
      FULL: begin
        if (out_xfer) begin
          state_nx = BUSY;
          main_nx  = skid_data;
          skid_nx  = '0;
        end
      end
      default: state_nx = EMPTY;
    endcase
    // Kill wins over any concurrent transfer; data registers keep stale contents.
    if (flush) begin
      state_nx = EMPTY;
      main_nx  = main_data;
      skid_nx  = skid_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      main_data <= main_nx;
      skid_data <= skid_nx;
      in_ready  <= (state_nx != FULL);
      out_valid <= (state_nx != EMPTY);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_skid_reg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipe_skid_reg : directed and random checks of pipe_skid_reg against a    |
// | two-entry FIFO queue model. Revision: 1.0                                   |
// +----------------------------------------------------------------------------+
module tb_pipe_skid_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  logic        in_ready1;
  logic        out_valid1;
  logic        out_data1;
  logic [1:0]  occupancy1;
  logic        in_data1;

  assign in_data1 = in_data[0];

  pipe_skid_reg #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_skid_reg #(.WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .occupancy(occupancy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total;
  int          passed;
  logic [31:0] q[$];
  logic        dx;
  logic        dy;
  logic [31:0] dz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic [31:0] head;
    chk("occupancy", {30'd0, occupancy}, q.size());
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() != 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("occupancy_w1", {30'd0, occupancy1}, q.size());
    chk("in_ready_w1", {31'd0, in_ready1}, {31'd0, q.size() < 2});
    if (q.size() != 0) begin
      head = q[0];
      chk("out_data", out_data, head);
      chk("out_data_w1", {31'd0, out_data1}, {31'd0, head[0]});
    end
  endtask

  // One clock: drive inputs, predict transfers from the model, advance, compare.
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy,
                      input logic fl, output logic in_x, output logic out_x,
                      output logic [31:0] pre_out);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    in_x      = iv && (q.size() < 2);
    out_x     = ordy && (q.size() > 0);
    pre_out   = out_data;
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(id);
    end
    check_outputs();
  endtask

  task automatic go(input logic iv, input logic [31:0] id, input logic ordy, input logic fl);
    step(iv, id, ordy, fl, dx, dy, dz);
  endtask

  initial begin
    int          sent;
    int          recv;
    int          cyc;
    int          max_occ;
    logic        iv;
    logic        ordy;
    logic        ix;
    logic        ox;
    logic        stalled;
    logic [31:0] held;
    logic [31:0] pre;

    total = 0; passed = 0;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    check_outputs();
    chk("reset_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Streaming, no bubbles
    go(1'b1, 32'h11, 1'b1, 1'b0);
    go(1'b1, 32'h22, 1'b1, 1'b0);
    go(1'b1, 32'h33, 1'b1, 1'b0);
    go(1'b1, 32'h44, 1'b1, 1'b0);
    go(1'b0, 32'h0, 1'b1, 1'b0);
    go(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure into skid, then ignored writes while full
    go(1'b1, 32'hA1, 1'b0, 1'b0);
    go(1'b1, 32'hA2, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) go(1'b1, 32'hFF, 1'b0, 1'b0);
    go(1'b0, 32'h0, 1'b1, 1'b0);
    go(1'b0, 32'h0, 1'b1, 1'b0);
    go(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with concurrent input and output transfers
    go(1'b1, 32'hB1, 1'b0, 1'b0);
    go(1'b1, 32'hB2, 1'b0, 1'b0);
    go(1'b1, 32'hCC, 1'b1, 1'b1);
    go(1'b0, 32'h0, 1'b1, 1'b0);
    go(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset while full
    go(1'b1, 32'hD1, 1'b0, 1'b0);
    go(1'b1, 32'hD2, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    check_outputs();
    chk("reset_mid_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    check_outputs();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) go(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic with scoreboard
    sent = 0; recv = 0; cyc = 0; max_occ = 0;
    while (recv < 1000 && cyc < 20000) begin
      iv      = ($urandom_range(0, 1) == 1) && (sent < 1000);
      ordy    = ($urandom_range(0, 1) == 1);
      stalled = (q.size() > 0) && !ordy;
      held    = (q.size() > 0) ? q[0] : 32'd0;
      step(iv, 32'h1000 + sent, ordy, 1'b0, ix, ox, pre);
      if (ox) begin
        chk("sb_order", pre, 32'h1000 + recv);
        recv++;
      end
      if (ix) sent++;
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, held);
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      cyc++;
    end
    chk("recv_count", recv, 32'd1000);
    chk("max_occupancy", max_occ, 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Elastic pipeline stage register with valid/ready handshake on both sides.
- Sits between two processor pipeline stages where the plain capture-every-cycle register is insufficient: the downstream stage can stall (backpressure).
- A main register plus a one-entry skid register give full throughput, meaning one transfer per cycle with no bubbles.
- in_ready is driven only by registers, so there is no combinational path from out_ready to in_ready.

Parameters:
- WIDTH, 32, payload width in bits.

Ports:
- clk        input   1      clock; all state updates on the rising edge.
- reset      input   1      asynchronous, active-high reset.
- flush      input   1      synchronous discard of all held entries (branch/exception kill).
- in_valid   input   1      upstream presents in_data.
- in_ready   output  1      stage can accept; registered.
- in_data    input   WIDTH  upstream payload.
- out_valid  output  1      out_data holds a valid entry.
- out_ready  input   1      downstream accepts out_data this cycle.
- out_data   output  WIDTH  payload to downstream; registered.
- occupancy  output  2      number of entries held: 0, 1 or 2.

Behaviour:
- Handshakes:
  - An input transfer occurs when in_valid && in_ready at a rising edge.
  - An output transfer occurs when out_valid && out_ready at a rising edge.
- Reset (async, any time, including mid-stall):
  - out_valid=0, out_data=0, in_ready=1, occupancy=0.
  - The skid register clears to 0.
  - Outputs are held until reset deasserts.
- States, encoded by (main_valid, skid_valid):
  - EMPTY (0,0): in_ready=1, out_valid=0.
    - Input transfer -> BUSY. in_data loads main; out_data and out_valid=1 appear the next cycle, so latency is 1 cycle.
  - BUSY (1,0): in_ready=1, out_valid=1.
    - Input and output transfer together -> stay BUSY; main loads the new in_data.
    - Output transfer only -> EMPTY.
    - Input transfer only (out_ready=0) -> FULL; in_data goes to skid and main is unchanged.
    - Neither -> hold.
  - FULL (1,1): in_ready=0, out_valid=1; in_valid is ignored.
    - Output transfer -> BUSY; skid moves to main and skid clears.
    - Otherwise -> hold.
- Ordering: strict FIFO order, with no loss or duplication.
- Stall stability: while out_valid && !out_ready, out_data and out_valid must not change, except under flush or reset.
- Upstream contract: in_data is sampled only on an input transfer; its value is don't-care otherwise.
- flush (synchronous):
  - At the edge where flush=1, go to EMPTY: out_valid=0 and in_ready=1 next cycle.
  - Any simultaneous input or output transfer is discarded; flush has priority.
  - Data registers keep their stale value; only the valid bits clear.
- occupancy: 0, 1 or 2 for EMPTY, BUSY or FULL; registered.
- in_ready equals !skid_valid, taken directly from a flop.
- No other state. The width is fully parameterised; WIDTH=1 must work.

Test Plan:
- Reset/idle: assert reset mid-run with occupancy=2 -> immediately out_valid=0, out_data=0, in_ready=1, occupancy=0; after release, no output appears without input.
- Streaming: out_ready=1, send 0x11,0x22,0x33,0x44 on consecutive cycles -> same values on out_data on consecutive cycles, each 1 cycle later; in_ready stays 1; no bubbles.
- Backpressure/skid: out_ready=0, send 0xA1 then 0xA2 ->
  - occupancy goes 1 then 2, in_ready=0, out_data=0xA1 held stable.
  - Raise out_ready -> 0xA1, then 0xA2 in order.
  - in_ready returns to 1 the cycle after the first drain.
- Full ignore: in FULL, drive in_valid=1 with in_data=0xFF for 3 cycles -> 0xFF is never output; contents stay 0xA1, 0xA2.
- Flush priority: occupancy=2 and flush=1 with in_valid=1 and out_ready=1 in the same cycle -> next cycle out_valid=0, occupancy=0, in_ready=1; neither held data nor the new input ever appears.
- Random: random in_valid/out_ready (50%), 1000 items with an incrementing payload -> scoreboard checks exact in-order delivery, checks stall stability every cycle, and sees occupancy reach 2 at least once.
